// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

   localparam int DIV_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/twos_negate.sv
// Two's-complement negation and absolute value of a WIDTH-bit value.
// The magnitude of the most-negative value comes out as 2^(WIDTH-1),
// which is correct when the result is read as unsigned.
module twos_negate #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] neg,
   output logic [WIDTH-1:0] abs
);

   assign neg = ~x + WIDTH'(1);
   assign abs = x[WIDTH-1] ? neg : x;

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: non-restoring shift/add-subtract loop on
// operand magnitudes, one quotient bit per clock, followed by a single
// correction/sign-fix cycle. Truncating quotient, remainder takes the
// dividend's sign. start/busy/done handshake toward the controller.
module booth_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] M,
   input  logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             dbz,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // state and datapath registers
   div_state_t         state_q, state_d;
   logic [WIDTH:0]     a_q, a_d;          // signed partial remainder
   logic [WIDTH-1:0]   qr_q, qr_d;        // dividend magnitude shifting into quotient
   logic [WIDTH-1:0]   mabs_q, mabs_d;    // divisor magnitude
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sq_q, sq_d;        // dividend sign
   logic               sm_q, sm_d;        // divisor sign
   logic               ovfc_q, ovfc_d;    // most-negative / -1 case pending
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // combinational helpers
   logic [WIDTH-1:0]   q_neg_s, q_abs_s;
   logic [WIDTH-1:0]   m_neg_s, m_abs_s;
   logic [WIDTH-1:0]   quot_neg_s, quot_abs_unused;
   logic [WIDTH-1:0]   rem_neg_s, rem_abs_unused;
   logic [WIDTH-1:0]   rem_mag_s;
   logic [WIDTH:0]     a_sh_s;
   logic [WIDTH:0]     m_ext_s;
   logic [WIDTH:0]     a_next_s;
   logic               q_mn_s;
   logic               m_neg1_s;

   twos_negate #(.WIDTH(WIDTH)) u_abs_q (
      .x   (Q),
      .neg (q_neg_s),
      .abs (q_abs_s)
   );

   twos_negate #(.WIDTH(WIDTH)) u_abs_m (
      .x   (M),
      .neg (m_neg_s),
      .abs (m_abs_s)
   );

   twos_negate #(.WIDTH(WIDTH)) u_neg_quot (
      .x   (qr_q),
      .neg (quot_neg_s),
      .abs (quot_abs_unused)
   );

   twos_negate #(.WIDTH(WIDTH)) u_neg_rem (
      .x   (rem_mag_s),
      .neg (rem_neg_s),
      .abs (rem_abs_unused)
   );

   // the most-negative value is the only nonzero value equal to its own negation
   assign q_mn_s   = Q[WIDTH-1] & (q_neg_s == Q);
   // -1 is the only value whose negation is +1
   assign m_neg1_s = (m_neg_s == WIDTH'(1));

   // one non-restoring step and the final remainder correction
   always_comb begin
      a_sh_s  = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
      m_ext_s = {1'b0, mabs_q};
      if (a_q[WIDTH]) begin
         a_next_s  = a_sh_s + m_ext_s;
         rem_mag_s = a_q[WIDTH-1:0] + mabs_q;
      end else begin
         a_next_s  = a_sh_s - m_ext_s;
         rem_mag_s = a_q[WIDTH-1:0];
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      qr_d    = qr_q;
      mabs_d  = mabs_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sm_d    = sm_q;
      ovfc_d  = ovfc_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sq_d   = Q[WIDTH-1];
               sm_d   = M[WIDTH-1];
               qr_d   = q_abs_s;
               mabs_d = m_abs_s;
               ovfc_d = q_mn_s & m_neg1_s;
               a_d    = '0;
               cnt_d  = '0;
               if (M == '0) begin
                  state_d = DONE;
                  quot_d  = {WIDTH{1'b1}};
                  rem_d   = Q;
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = RUN;
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_next_s;
            qr_d  = {qr_q[WIDTH-2:0], ~a_next_s[WIDTH]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end else begin
               state_d = RUN;
            end
         end
         FIX: begin
            a_d     = {1'b0, rem_mag_s};
            state_d = DONE;
            if (ovfc_q) begin
               quot_d = {1'b1, {(WIDTH-1){1'b0}}};
               rem_d  = '0;
               ovf_d  = 1'b1;
            end else begin
               quot_d = (sq_q ^ sm_q) ? quot_neg_s : qr_q;
               rem_d  = sq_q ? rem_neg_s : rem_mag_s;
               ovf_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   // state/datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         qr_q    <= '0;
         mabs_q  <= '0;
         cnt_q   <= '0;
         sq_q    <= 1'b0;
         sm_q    <= 1'b0;
         ovfc_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         qr_q    <= qr_d;
         mabs_q  <= mabs_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sm_q    <= sm_d;
         ovfc_q  <= ovfc_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;
   assign rem  = rem_q;
   assign dbz  = dbz_q;
   assign ovf  = ovf_q;

endmodule
